// File: rtl/demux1_4_data.sv
// demux1_4_data: registered 1-to-4 data distributor with per-lane valid/ready and round-robin or explicit lane select
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_data/in_valid     input sample and its valid
//   in_ready             combinational accept indication (never depends on in_valid)
//   sel1, sel2           explicit lane select {sel1,sel2}, used when auto_en = 0
//   auto_en              1: round-robin pointer picks the lane
//   lanes                active lanes minus 1 for round-robin
//   clr                  synchronous clear of valids, pointer and wrap
//   out1..out4           lane holding registers
//   out_valid/out_ready  per-lane handshake toward the window lanes
//   ptr, wrap            round-robin pointer and its wrap pulse
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
module demux1_4_data (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [`DATA_LENGTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sel1,
    input  logic                    sel2,
    input  logic                    auto_en,
    input  logic [1:0]              lanes,
    input  logic                    clr,
    output logic [`DATA_LENGTH-1:0] out1,
    output logic [`DATA_LENGTH-1:0] out2,
    output logic [`DATA_LENGTH-1:0] out3,
    output logic [`DATA_LENGTH-1:0] out4,
    output logic [3:0]              out_valid,
    input  logic [3:0]              out_ready,
    output logic [1:0]              ptr,
    output logic                    wrap
);
    logic [3:0][`DATA_LENGTH-1:0] r_data;
    logic [3:0]                   r_valid;
    logic [1:0]                   r_ptr;
    logic                         r_wrap;
    logic [1:0]                   w_eff;
    logic [1:0]                   w_tgt;
    logic [1:0]                   w_ptr_nxt;
    logic                         w_acc;
    logic [3:0]                   w_valid_nxt;
    // A pointer left beyond a shrunken lane count restarts at lane 1.
    assign w_eff     = (r_ptr > lanes) ? 2'd0 : r_ptr;
    assign w_tgt     = auto_en ? w_eff : {sel1, sel2};
    assign w_ptr_nxt = (w_eff == lanes) ? 2'd0 : w_eff + 2'd1;
    assign in_ready  = ~clr & (~r_valid[w_tgt] | out_ready[w_tgt]);
    assign w_acc     = in_valid & in_ready;
    always_comb begin
        w_valid_nxt = r_valid & ~out_ready;
        if (w_acc) w_valid_nxt[w_tgt] = 1'b1;
        if (clr) w_valid_nxt = '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= '0;
            r_ptr   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            if (w_acc) r_data[w_tgt] <= in_data;
            r_valid <= w_valid_nxt;
            r_ptr   <= clr ? 2'd0 : (auto_en & w_acc) ? w_ptr_nxt : r_ptr;
            r_wrap  <= auto_en & w_acc & (w_eff == lanes);
        end
    end
    assign out1      = r_data[0];
    assign out2      = r_data[1];
    assign out3      = r_data[2];
    assign out4      = r_data[3];
    assign out_valid = r_valid;
    assign ptr       = r_ptr;
    assign wrap      = r_wrap;
endmodule

// File: tb/tb_demux1_4_data.sv
// tb_demux1_4_data: directed scenarios plus random traffic checked against a lane/valid/pointer reference model
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif
module tb_demux1_4_data;
    localparam int DL = `DATA_LENGTH;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [DL-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          sel1, sel2, auto_en, clr;
    logic [1:0]    lanes;
    logic [DL-1:0] out1, out2, out3, out4;
    logic [3:0]    out_valid, out_ready;
    logic [1:0]    ptr;
    logic          wrap;
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DL-1:0] m_data [4];
    logic [3:0]    m_valid;
    int            m_ptr;
    logic          m_wrap;
    demux1_4_data dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sel1(sel1), .sel2(sel2), .auto_en(auto_en), .lanes(lanes), .clr(clr),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(out_valid), .out_ready(out_ready), .ptr(ptr), .wrap(wrap)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic int m_eff();
        return (m_ptr > int'(lanes)) ? 0 : m_ptr;
    endfunction
    function automatic int m_tgt();
        return auto_en ? m_eff() : 2 * int'(sel1) + int'(sel2);
    endfunction
    function automatic logic m_rdy();
        return !clr && (!m_valid[m_tgt()] || out_ready[m_tgt()]);
    endfunction
    task automatic m_reset();
        for (int k = 0; k < 4; k++) m_data[k] = '0;
        m_valid = '0;
        m_ptr   = 0;
        m_wrap  = 1'b0;
    endtask
    task automatic check_outs(input string tag);
        check({tag, ".out1"}, 32'(out1), 32'(m_data[0]));
        check({tag, ".out2"}, 32'(out2), 32'(m_data[1]));
        check({tag, ".out3"}, 32'(out3), 32'(m_data[2]));
        check({tag, ".out4"}, 32'(out4), 32'(m_data[3]));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    endtask
    // One clock: check in_ready against the model, advance the model by the spec rules, check outputs after the edge.
    task automatic step(input string tag);
        int  t, e;
        logic acc;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(m_rdy()));
        t   = m_tgt();
        e   = m_eff();
        acc = in_valid && m_rdy();
        @(posedge clk);
        if (clr) begin
            m_valid = '0;
            m_ptr   = 0;
            m_wrap  = 1'b0;
        end else begin
            m_valid = m_valid & ~out_ready;
            m_wrap  = 1'b0;
            if (acc) begin
                m_data[t]  = in_data;
                m_valid[t] = 1'b1;
                if (auto_en) begin
                    m_wrap = (e == int'(lanes));
                    m_ptr  = m_wrap ? 0 : e + 1;
                end
            end
        end
        #1;
        check_outs(tag);
    endtask
    task automatic send(input string tag, input logic [DL-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step(tag);
        in_valid = 1'b0;
    endtask
    // Asserts rst_n between edges and checks the forced state before any clock.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_outs(tag);
        rst_n = 1'b1;
        #1;
    endtask
    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; sel1 = 1'b0; sel2 = 1'b0;
        auto_en = 1'b0; lanes = 2'd3; clr = 1'b0; out_ready = 4'b0000;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_outs("reset");
        check("reset.in_ready", 32'(in_ready), 32'd1);
        // fill lanes 1 and 3, then reset between edges
        send("fill1", 8'hC1);
        {sel1, sel2} = 2'b10;
        send("fill3", 8'hC3);
        check("fill.valid", 32'(out_valid), 32'b0101);
        mid_reset("midrst");
        check("midrst.out3", 32'(out3), 32'd0);
        // auto round-robin over three lanes
        auto_en = 1'b1; lanes = 2'd2; out_ready = 4'b1111;
        send("rr1", 8'h11);
        check("rr1.ptr", 32'(ptr), 32'd1);
        send("rr2", 8'h22);
        send("rr3", 8'h33);
        check("rr3.wrap", 32'(wrap), 32'd1);
        check("rr3.ptr", 32'(ptr), 32'd0);
        send("rr4", 8'h44);
        check("rr4.out1", 32'(out1), 32'h44);
        check("rr4.wrap", 32'(wrap), 32'd0);
        // explicit lane 3 with a stalled consumer
        auto_en = 1'b0; {sel1, sel2} = 2'b10; out_ready = 4'b1011;
        send("ex1", 8'hA5);
        check("ex1.out3", 32'(out3), 32'hA5);
        in_data = 8'h5A; in_valid = 1'b1;
        #1 check("ex2.in_ready", 32'(in_ready), 32'd0);
        step("ex2");
        out_ready = 4'b1111;
        step("ex3");
        in_valid = 1'b0;
        check("ex3.out3", 32'(out3), 32'h5A);
        check("ex3.valid2", 32'(out_valid[2]), 32'd1);
        // lane shrink with the pointer beyond the new count
        auto_en = 1'b1; lanes = 2'd3;
        send("shr_a", 8'h01);
        send("shr_b", 8'h02);
        check("shr.ptr3", 32'(ptr), 32'd3);
        lanes = 2'd1;
        send("shr", 8'h77);
        check("shr.out1", 32'(out1), 32'h77);
        check("shr.ptr", 32'(ptr), 32'd1);
        check("shr.wrap", 32'(wrap), 32'd0);
        // clear beats a simultaneous accept
        out_ready = 4'b0000;
        send("pre_clr", 8'h42);
        clr = 1'b1; in_data = 8'h99; in_valid = 1'b1;
        step("clr");
        clr = 1'b0; in_valid = 1'b0;
        check("clr.out2", 32'(out2), 32'h42);
        check("clr.valid", 32'(out_valid), 32'd0);
        // mode switch keeps the pointer
        out_ready = 4'b1111; lanes = 2'd3;
        send("ms_a", 8'h03);
        send("ms_b", 8'h04);
        auto_en = 1'b0; {sel1, sel2} = 2'b00;
        send("ms_ex", 8'h10);
        check("ms_ex.out1", 32'(out1), 32'h10);
        check("ms_ex.ptr", 32'(ptr), 32'd2);
        auto_en = 1'b1;
        send("ms_auto", 8'h20);
        check("ms_auto.out3", 32'(out3), 32'h20);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_data   = DL'($urandom);
            in_valid  = 1'($urandom);
            {sel1, sel2} = 2'($urandom);
            auto_en   = ($urandom_range(3) != 0);
            lanes     = ($urandom_range(7) == 0) ? 2'($urandom) : lanes;
            clr       = ($urandom_range(15) == 0);
            out_ready = 4'($urandom);
            step("rand");
            if ($urandom_range(63) == 0) begin
                clr = 1'b0;
                mid_reset("rand_rst");
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/demux1_4_data.md
# demux1_4_data

Registered 1-to-4 data distributor for the variable-size median datapath. It is the write-side counterpart of the 4:1 data selector. It takes one sample stream and steers each word into one of four lane holding registers, each with a valid/ready handshake toward the window lanes. The lane is chosen either by an explicit select or by a round-robin pointer bounded by the active window width.

## Interface
- `DATA_LENGTH`: width of one sample, taken from the `macro.vh` macro; there is no module parameter.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_data`  in  `DATA_LENGTH`  input sample.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `sel1`, `sel2`  in  1 each  explicit lane select. `{sel1,sel2}` 00→lane1, 01→lane2, 10→lane3, 11→lane4.
- `auto_en`  in  1  1: round-robin pointer selects the lane; 0: `{sel1,sel2}` selects the lane.
- `lanes`  in  2  number of active lanes minus 1 (0..3); used in auto mode only.
- `clr`  in  1  synchronous clear.
- `out1`..`out4`  out  `DATA_LENGTH` each  lane holding registers.
- `out_valid`  out  4  bit k = lane k+1 holds an undelivered word.
- `out_ready`  in  4  bit k = lane k+1 consumer takes its word.
- `ptr`  out  2  round-robin pointer.
- `wrap`  out  1  one-cycle pulse when the pointer wraps to 0.

## Operation
**Target lane.**
- `t = auto_en ? eff : {sel1,sel2}`.
- `eff = (ptr > lanes) ? 0 : ptr`. This guards against `lanes` shrinking mid-stream.

**Handshake.**
- `in_ready = ~clr & (~out_valid[t] | out_ready[t])`. This is combinational; drain and refill of a lane in the same cycle is allowed.
- An accept occurs when `in_valid & in_ready`.

**Accept.**
- Lane t register takes `in_data` and `out_valid[t]` is set to 1.
- If lane t also drains in the same cycle, `out_valid[t]` stays 1 and the new data replaces the old.
- A lane with no accept clears its `out_valid` bit when `out_valid & out_ready` are both 1.
- Lane registers hold their value when the lane is idle.

**Pointer.**
- Auto mode, on accept: `ptr ← (eff == lanes) ? 0 : eff+1`.
- When the pointer wraps to 0, `wrap` is 1 for the next cycle.
- Explicit mode: `ptr` holds and `wrap` is 0.
- Toggling `auto_en` does not modify `ptr`.
- In auto mode with no accept, `ptr` holds, even when `ptr > lanes`.

**Clear.** `clr` has priority over accept and drain. On the next edge:
- `out_valid = 0`, `ptr = 0`, `wrap = 0`.
- Lane data registers are unchanged.
- No word is accepted in the `clr` cycle.

**Reset.** `rst_n` low immediately forces:
- `out1`..`out4 = 0`, `out_valid = 0`, `ptr = 0`, `wrap = 0`.
- In-flight words are discarded.
- `in_ready` reads 1 (when `clr = 0`), because all valids are 0.

**Lane independence.** Consumers on non-target lanes drain independently in the same cycle as an accept on lane t.

## Timing
- Latency: accept at edge n → `outk`/`out_valid[k]` visible after edge n.
- Throughput: one word per cycle when the target lane is empty or draining.
- `in_ready` depends combinationally on `auto_en`, `sel1`, `sel2`, `lanes`, `clr`, `out_ready` and registered state. It is never a function of `in_valid`.
- `wrap` is registered, so it rises in the cycle after the wrapping accept.
- Reset release: `rst_n` is synchronised externally. The first accept can occur on the first edge after release.

## Test plan
- **Reset mid-operation.** Fill lanes 1 and 3, then pulse `rst_n` low between edges → `out_valid = 0000`, `out1 = out3 = 0`, `ptr = 0` without waiting for a clock.
- **Auto, `lanes = 2`.** Stream 0x11, 0x22, 0x33, 0x44 with `out_ready = 1111` → lane1 = 0x11, lane2 = 0x22, lane3 = 0x33, lane1 = 0x44; `ptr` goes 1, 2, 0, 1; `wrap` is high one cycle after 0x33.
- **Explicit, `{sel1,sel2} = 10`, `out_ready[2] = 0`.**
  - 0xA5 is accepted into `out3`; the next word sees `in_ready = 0`.
  - Raise `out_ready[2]` → 0x5A is accepted in the same cycle, `out_valid[2]` stays 1, `out3 = 0x5A`.
- **Lane shrink.** With `ptr = 3`, set `lanes = 1` and send 0x77 → it lands in `out1`; `ptr = 1`; `wrap = 0`.
- **Clear vs. accept.** `clr = 1` with `in_valid = 1` and 0x99 → `in_ready = 0`, no lane loads 0x99, `out_valid = 0000`, `ptr = 0`; old `out2` data is unchanged.
- **Mode switch.** With auto `ptr = 2`, switch to explicit `sel = 00` and send 0x10 → it goes to `out1` and `ptr` stays 2. Return to auto and send 0x20 → it goes to `out3`.
